// File: rtl/wide_add_seq_if.sv
// wide_add_seq_if: request/response handshake and shared 32-bit adder port bundle
interface wide_add_seq_if #(
    parameter int WORDS = 4
);
    localparam int W = 32 * WORDS;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         carry_out;
    logic         overflow;
    logic         busy;
    logic [31:0]  adder_a;
    logic [31:0]  adder_b;
    logic         adder_cin;
    logic [31:0]  adder_s;
    logic         adder_cout;

    modport slave (
        input  in_valid, op_a, op_b, sub, out_ready, adder_s, adder_cout,
        output in_ready, out_valid, result, carry_out, overflow, busy,
               adder_a, adder_b, adder_cin
    );

    modport master (
        output in_valid, op_a, op_b, sub, out_ready, adder_s, adder_cout,
        input  in_ready, out_valid, result, carry_out, overflow, busy,
               adder_a, adder_b, adder_cin
    );
endinterface

// File: rtl/wide_add_seq.sv
// wide_add_seq: multi-limb add/subtract sequenced through a shared, pipelined 32-bit adder
module wide_add_seq #(
    parameter int WORDS     = 4,
    parameter int ADDER_LAT = 1
) (
    input logic          clk,
    input logic          rst,
    wide_add_seq_if.slave bus
);
    localparam int W  = 32 * WORDS;
    localparam int IW = WORDS > 1 ? $clog2(WORDS) : 1;
    localparam int CW = 2;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  a_q, b_q, res_q;
    logic          sub_q, carry_q, cout_q, ovf_q;
    logic          accept, capture, last_limb, active;

    assign accept    = state_q == IDLE && bus.in_valid;
    assign capture   = state_q == WAIT && cnt_q == CW'(ADDER_LAT - 1);
    assign last_limb = idx_q == IW'(WORDS - 1);
    assign active    = state_q == ISSUE || state_q == WAIT;

    // Next state: one ISSUE cycle then ADDER_LAT WAIT cycles per limb, low limb first
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d = ISSUE;
                    idx_d   = '0;
                end
            end
            ISSUE: begin
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: begin
                if (capture) begin
                    state_d = last_limb ? DONE : ISSUE;
                    idx_d   = last_limb ? idx_q : idx_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: state_d = bus.out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    // Control registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    // Operand latch on accept; B is stored already inverted for subtraction
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            sub_q <= 1'b0;
        end else if (accept) begin
            a_q   <= bus.op_a;
            b_q   <= bus.sub ? ~bus.op_b : bus.op_b;
            sub_q <= bus.sub;
        end
    end

    // Limb capture from the adder; flags are taken when the top limb lands
    always_ff @(posedge clk) begin
        if (rst) begin
            res_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (capture) begin
            res_q[idx_q*32 +: 32] <= bus.adder_s;
            carry_q               <= bus.adder_cout;
            if (last_limb) begin
                cout_q <= bus.adder_cout;
                ovf_q  <= (a_q[W-1] == b_q[W-1]) && (bus.adder_s[31] != a_q[W-1]);
            end
        end
    end

    assign bus.in_ready  = state_q == IDLE;
    assign bus.busy      = state_q != IDLE;
    assign bus.out_valid = state_q == DONE;
    assign bus.result    = res_q;
    assign bus.carry_out = cout_q;
    assign bus.overflow  = ovf_q;
    assign bus.adder_a   = active ? a_q[idx_q*32 +: 32] : 32'd0;
    assign bus.adder_b   = active ? b_q[idx_q*32 +: 32] : 32'd0;
    assign bus.adder_cin = active && (idx_q == '0 ? sub_q : carry_q);
endmodule

// File: doc/wide_add_seq.md
WIDE_ADD_SEQ -- requirements
Module: wide_add_seq

Interface
REQ-001 SHALL have parameter WORDS, default 4, giving the number of 32-bit limbs per operand; operand width is W = 32*WORDS.
REQ-002 SHALL have parameter ADDER_LAT, default 1, giving the registered latency of the external 32-bit prefix adder in clk cycles; legal range is 1..4.
REQ-003 SHALL use clk, in, 1, as the single clock; all state updates on the rising edge.
REQ-004 SHALL use rst, in, 1, as a synchronous, active-high reset.
REQ-005 SHALL have in_valid, in, 1: request present.
REQ-006 SHALL have in_ready, out, 1: request can be accepted.
REQ-007 SHALL have op_a, in, W: operand A.
REQ-008 SHALL have op_b, in, W: operand B.
REQ-009 SHALL have sub, in, 1: 0 computes A+B, 1 computes A-B.
REQ-010 SHALL have out_valid, out, 1: result present.
REQ-011 SHALL have out_ready, in, 1: consumer accepts the result.
REQ-012 SHALL have result, out, W: the sum or difference.
REQ-013 SHALL have carry_out, out, 1: raw carry from the top limb (for sub, 1 means no borrow).
REQ-014 SHALL have overflow, out, 1: two's-complement signed overflow.
REQ-015 SHALL have busy, out, 1: high in every state other than IDLE.
REQ-016 SHALL have adder_a, out, 32; adder_b, out, 32; and adder_cin, out, 1, which drive the shared prefix adder.
REQ-017 SHALL have adder_s, in, 32, and adder_cout, in, 1, which return the adder sum and carry.

Function
REQ-018 SHALL implement the states IDLE, ISSUE, WAIT and DONE.
REQ-019 SHALL drive in_ready=1 only in IDLE; a request is accepted on any edge where in_valid and in_ready are both high.
REQ-020 On acceptance, SHALL latch op_a, op_b and sub, clear the limb index to 0, and go to ISSUE.
REQ-021 In ISSUE for limb i, SHALL drive:
- adder_a = A[32i+31:32i];
- adder_b = B limb, bitwise inverted when sub=1;
- adder_cin = sub when i=0, otherwise the stored carry.
REQ-022 SHALL hold adder_a, adder_b and adder_cin stable from ISSUE through the end of WAIT for the same limb.
REQ-023 SHALL stay in WAIT for exactly ADDER_LAT cycles.
- On the last WAIT cycle's edge: capture adder_s into result limb i and adder_cout into the carry register.
- If i < WORDS-1: increment i and go to ISSUE.
- Otherwise: go to DONE.
REQ-024 Each limb SHALL take ADDER_LAT+1 cycles; out_valid SHALL rise exactly WORDS*(ADDER_LAT+1) edges after the accepting edge (8 with the defaults).
REQ-025 carry_out SHALL equal the carry captured from limb WORDS-1.
REQ-026 overflow SHALL be 1 iff A[W-1] equals the effective B[W-1] (after inversion for sub) and result[W-1] differs from A[W-1].
REQ-027 In DONE, SHALL hold out_valid=1 and keep result, carry_out and overflow stable until out_ready=1.
- On that edge: out_valid falls and the state returns to IDLE.
- A new request is acceptable no earlier than the following cycle.
REQ-028 SHALL ignore in_valid while busy and SHALL NOT sample op_a, op_b or sub outside the accepting edge.
REQ-029 Outside ISSUE and WAIT, SHALL drive adder_a, adder_b and adder_cin to 0.
REQ-030 result, carry_out and overflow SHALL retain the last completed operation's values while in IDLE.

Reset
REQ-031 With rst=1 at an edge, SHALL go to IDLE and set:
- out_valid=0, busy=0, result=0, carry_out=0, overflow=0;
- the carry register to 0 and the limb index to 0;
- adder_a, adder_b and adder_cin to 0.
REQ-032 rst SHALL take priority over all other inputs, including in_valid, and over any operation in progress.
REQ-033 in_ready SHALL be 1 on the first cycle after rst deasserts.

Verification
REQ-034 A=0x0000_0000_0000_0000_0000_0000_7FFF_FFFF, B=1, sub=0 -> result=0x...0000_0000_8000_0000, carry_out=0, overflow=0; out_valid rises 8 edges after accept.
REQ-035 A=all ones, B=1, sub=0 -> result=0, carry_out=1, overflow=0; the carry ripples through all 4 limbs via adder_cin=1 on limbs 1..3.
REQ-036 A=5, B=7, sub=1 -> result=0xFFFF..FFFE, carry_out=0, overflow=0; A=7, B=5, sub=1 -> result=2, carry_out=1.
REQ-037 A=0x7FFF..FFFF, B=1, sub=0 -> result=0x8000..0000, overflow=1.
REQ-038 Backpressure: hold out_ready=0 for 5 cycles after out_valid -> result stable, in_ready=0, and in_valid is ignored; out_ready=1 -> IDLE on the next cycle.
REQ-039 Reset mid-operation:
- Assert rst in WAIT of limb 2 -> next cycle IDLE, out_valid=0, result=0, adder inputs 0.
- A fresh request afterwards completes with correct values.
- Repeat with ADDER_LAT=3: out_valid rises after 16 edges.
